// File: rtl/bloom_set_p.sv
// Partitioned Bloom set: K single-bit banks addressed by H3 hashes of the key.
// Two-stage pipeline: hash register (S1), then bank read/update into the output register (S2).
module bloom_set_p #(
  parameter int DATA_W = 59,
  parameter int K      = 9,
  parameter int HASH_W = 7,
  parameter int CNT_W  = 16,
  parameter int CAP    = 100
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              match_o,
  output logic [1:0]        op_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o
);

  localparam logic [1:0] OP_QUERY  = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_TAI    = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  localparam int               DEPTH   = 1 << HASH_W;
  localparam logic [CNT_W:0]   CAP_EXT = (CNT_W + 1)'(CAP);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Elaboration-time H3 row for hash k, data bit i.
  function automatic logic [HASH_W-1:0] h3_row(input int k, input int i);
    logic [31:0] x;
    x = (32'(i + 1) * 32'h9E3779B1) ^ (32'(k + 1) * 32'h85EBCA77);
    x = x ^ (x >> 15);
    return x[HASH_W-1:0];
  endfunction

  logic                          stall;
  logic                          advance;
  logic                          s1_fire;
  logic                          s1_valid_reg;
  logic [1:0]                    s1_op_reg;
  logic [K-1:0][HASH_W-1:0]      hash_now;
  logic [K-1:0][HASH_W-1:0]      s1_hash_reg;
  logic [K-1:0]                  rd_bits;
  logic                          hit;
  logic                          do_set;
  logic                          do_clear;
  logic                          cnt_inc;
  logic                          out_valid_reg;
  logic                          match_reg;
  logic [1:0]                    op_reg;
  logic [CNT_W-1:0]              count_reg;

  assign stall      = out_valid_reg && !out_ready_i;
  assign advance    = !stall;
  assign in_ready_o = advance;
  assign s1_fire    = advance && s1_valid_reg;

  generate
    for (genvar gk = 0; gk < K; gk++) begin : g_hash
      logic [DATA_W-1:0][HASH_W-1:0] term;
      logic [HASH_W-1:0]             acc;
      for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
        localparam logic [HASH_W-1:0] ROW = h3_row(gk, gi);
        assign term[gi] = data_i[gi] ? ROW : '0;
      end
      always_comb begin
        acc = '0;
        for (int i = 0; i < DATA_W; i++) begin
          acc = acc ^ term[i];
        end
      end
      assign hash_now[gk] = acc;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      s1_valid_reg <= 1'b0;
      s1_op_reg    <= OP_QUERY;
      s1_hash_reg  <= '0;
    end else if (advance) begin
      s1_valid_reg <= in_valid_i;
      if (in_valid_i) begin
        s1_op_reg   <= op_i;
        s1_hash_reg <= hash_now;
      end
    end
  end

  assign do_set   = (s1_op_reg == OP_INSERT) || (s1_op_reg == OP_TAI);
  assign do_clear = (s1_op_reg == OP_CLEAR);
  assign hit      = &rd_bits;
  assign cnt_inc  = do_set && !hit && (count_reg != CNT_MAX);

  // Banks are flops rather than RAM so a clear can wipe every bit in one cycle.
  generate
    for (genvar gk = 0; gk < K; gk++) begin : g_bank
      logic [DEPTH-1:0] bits_reg;
      assign rd_bits[gk] = bits_reg[s1_hash_reg[gk]];
      always_ff @(posedge clk_i) begin
        if (!rst_i || (s1_fire && do_clear)) begin
          bits_reg <= '0;
        end else if (s1_fire && do_set) begin
          bits_reg[s1_hash_reg[gk]] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_reg <= '0;
    end else if (s1_fire) begin
      if (do_clear) begin
        count_reg <= '0;
      end else if (cnt_inc) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      out_valid_reg <= 1'b0;
      match_reg     <= 1'b0;
      op_reg        <= OP_QUERY;
    end else if (advance) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        match_reg <= ((s1_op_reg == OP_QUERY) || (s1_op_reg == OP_TAI)) && hit;
        op_reg    <= s1_op_reg;
      end
    end
  end

  assign out_valid_o = out_valid_reg;
  assign match_o     = match_reg;
  assign op_o        = op_reg;
  assign count_o     = count_reg;
  assign full_o      = {1'b0, count_reg} >= CAP_EXT;

endmodule
